// File: rtl/vec_reduce_unit_pkg.sv
// Shared definitions for the vector reduction unit: op codes, FSM states, defaults, init helper.
// Optional feature macro: VEC_REDUCE_MAX_EN (signed MAX reduction on op 2'b10).
package vec_reduce_unit_pkg;

    localparam int DEF_NUM_ELEM   = 8;
    localparam int DEF_REG_WIDTH  = 256;
    localparam int DEF_ELEM_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 5;

    localparam logic [31:0] RED_MAX_INIT = 32'h8000_0000;

`ifdef VEC_REDUCE_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        RED_SUM  = 2'b00,
        RED_XOR  = 2'b01,
        RED_MAX  = 2'b10,
        RED_RSVD = 2'b11
    } red_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } red_state_e;

    // MAX starts from the most negative value; every other op (and MAX when disabled) starts at 0.
    function automatic logic red_uses_max_init(input red_op_e op);
        return MAX_EN && (op == RED_MAX);
    endfunction

endpackage

// File: rtl/vec_reduce_unit_if.sv
// Handshake bundle between the vector ALU, the reduction unit and scalar writeback.
interface vec_reduce_unit_if #(
    parameter int REG_WIDTH  = vec_reduce_unit_pkg::DEF_REG_WIDTH,
    parameter int ELEM_WIDTH = vec_reduce_unit_pkg::DEF_ELEM_WIDTH,
    parameter int TAG_WIDTH  = vec_reduce_unit_pkg::DEF_TAG_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_WIDTH-1:0]  in_vec;
    logic [1:0]            in_op;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [ELEM_WIDTH-1:0] out_scalar;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_zero;

    modport slave (
        input  in_valid, in_vec, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_scalar, out_tag, out_zero
    );

    modport master (
        output in_valid, in_vec, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_scalar, out_tag, out_zero
    );
endinterface

// File: rtl/vec_reduce_combine.sv
// One reduction step: folds a single lane into the running accumulator for the selected op.
// The signed comparator only exists when VEC_REDUCE_MAX_EN is defined.
module vec_reduce_combine
    import vec_reduce_unit_pkg::*;
#(
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH
) (
    input  logic [ELEM_WIDTH-1:0] acc,
    input  logic [ELEM_WIDTH-1:0] lane,
    input  red_op_e               op,
    output logic [ELEM_WIDTH-1:0] next_acc
);

    // Next accumulator value; reserved op pins the result to zero.
    always_comb begin
        next_acc = {ELEM_WIDTH{1'b0}};
        case (op)
            RED_SUM: next_acc = acc + lane;
            RED_XOR: next_acc = acc ^ lane;
`ifdef VEC_REDUCE_MAX_EN
            RED_MAX: begin
                // Ties keep the accumulator.
                if ($signed(lane) > $signed(acc)) begin
                    next_acc = lane;
                end else begin
                    next_acc = acc;
                end
            end
`else
            RED_MAX: next_acc = {ELEM_WIDTH{1'b0}};
`endif
            default: next_acc = {ELEM_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/vec_reduce_unit.sv
// Serial horizontal reduction of one ALU vector into a tagged scalar, one lane per cycle.
// Optional feature macro: VEC_REDUCE_MAX_EN (enables signed MAX on op 2'b10).
module vec_reduce_unit
    import vec_reduce_unit_pkg::*;
#(
    parameter int NUM_ELEM   = DEF_NUM_ELEM,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    vec_reduce_unit_if.slave  bus,
    output logic              busy
);

    localparam int CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [CNT_W-1:0]      LAST_C     = CNT_W'(NUM_ELEM - 1);
    localparam logic [ELEM_WIDTH-1:0] MAX_INIT_C = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    red_state_e            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [REG_WIDTH-1:0]  vec_r;
    red_op_e               op_r;
    logic [TAG_WIDTH-1:0]  tag_r;
    logic [ELEM_WIDTH-1:0] acc_r;
    logic [ELEM_WIDTH-1:0] lane_s;
    logic [ELEM_WIDTH-1:0] next_acc_s;
    red_op_e               in_op_s;

    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [ELEM_WIDTH-1:0] out_scalar_r;
    logic [TAG_WIDTH-1:0]  out_tag_r;
    logic                  out_zero_r;
    logic                  busy_r;

    // The latched vector is shifted down each step, so the current lane always sits at the bottom.
    assign lane_s  = vec_r[ELEM_WIDTH-1:0];
    assign in_op_s = red_op_e'(bus.in_op);

    vec_reduce_combine #(
        .ELEM_WIDTH (ELEM_WIDTH)
    ) u_combine (
        .acc      (acc_r),
        .lane     (lane_s),
        .op       (op_r),
        .next_acc (next_acc_s)
    );

    // FSM, lane counter, operand capture and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            vec_r        <= {REG_WIDTH{1'b0}};
            op_r         <= RED_SUM;
            tag_r        <= {TAG_WIDTH{1'b0}};
            acc_r        <= {ELEM_WIDTH{1'b0}};
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_scalar_r <= {ELEM_WIDTH{1'b0}};
            out_tag_r    <= {TAG_WIDTH{1'b0}};
            out_zero_r   <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        vec_r      <= bus.in_vec;
                        op_r       <= in_op_s;
                        tag_r      <= bus.in_tag;
                        cnt_r      <= {CNT_W{1'b0}};
                        acc_r      <= red_uses_max_init(in_op_s) ? MAX_INIT_C : {ELEM_WIDTH{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_r <= next_acc_s;
                    vec_r <= vec_r >> ELEM_WIDTH;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_C) begin
                        out_scalar_r <= next_acc_s;
                        out_zero_r   <= (next_acc_s == {ELEM_WIDTH{1'b0}});
                        out_tag_r    <= tag_r;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE re-opens the input only on the next cycle.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_scalar = out_scalar_r;
    assign bus.out_tag    = out_tag_r;
    assign bus.out_zero   = out_zero_r;
    assign busy           = busy_r;

endmodule
